// File: rtl/mor1kx_rf_multiport.sv
// Multi-read-port GPR file with a post-reset clear sweep and registered read outputs.
// Optional macro MOR1KX_RF_BYPASS_EN adds write-to-read forwarding on every read port.
module mor1kx_rf_multiport #(
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_RF_WORDS      = 32,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_READ_PORTS = 2,
    parameter int OPTION_RF_ZERO_R0    = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 padv_decode_i,
    input  logic [OPTION_RF_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]                      rfd_adr_i,
    input  logic                                                 rf_wb_i,
    input  logic                                                 execute_rf_we_i,
    input  logic                                                 write_mask_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]                      result_i,
    output logic [OPTION_RF_READ_PORTS*OPTION_OPERAND_WIDTH-1:0] rd_data_o,
    output logic                                                 init_busy_o
);
    localparam int AW  = OPTION_RF_ADDR_WIDTH;
    localparam int AW1 = OPTION_RF_ADDR_WIDTH + 1;
    localparam int W   = OPTION_OPERAND_WIDTH;
    localparam int P   = OPTION_RF_READ_PORTS;
    localparam bit ZR0 = (OPTION_RF_ZERO_R0 != 0);

    localparam logic [0:0]    S_INIT = 1'b0;
    localparam logic [0:0]    S_RUN  = 1'b1;
    localparam logic [AW-1:0] LAST   = AW'(OPTION_RF_WORDS - 1);
    localparam logic [AW:0]   NWORDS = AW1'(OPTION_RF_WORDS);

    logic [0:0]            r_state;
    logic [AW-1:0]         r_clr_cnt;
    logic [AW-1:0]         r_rfd;
    logic [P-1:0][AW-1:0]  r_rd;
    logic [P-1:0][W-1:0]   r_out;
    logic [W-1:0]          r_mem [0:OPTION_RF_WORDS-1];

    logic                  w_run;
    logic                  w_wren;
    logic                  w_mem_we;
    logic                  w_cap;
    logic [P-1:0][AW-1:0]  w_adr;
    logic [P-1:0][W-1:0]   w_rd_val;
`ifdef MOR1KX_RF_BYPASS_EN
    logic [P-1:0]          w_hold_byp;
`endif

    assign w_run       = (r_state == S_RUN);
    assign w_wren      = execute_rf_we_i & rf_wb_i & ~write_mask_i & w_run;
    assign w_mem_we    = w_wren && ({1'b0, r_rfd} < NWORDS) && !(ZR0 && r_rfd == '0);
    assign w_cap       = padv_decode_i & w_run;
    assign w_adr       = rd_adr_i;
    assign init_busy_o = (r_state == S_INIT);
    assign rd_data_o   = r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST)
                r_state <= S_RUN;
        end
    end

    // Storage is not reset: the INIT sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT)
            r_mem[r_clr_cnt] <= '0;
        else if (w_mem_we)
            r_mem[r_rfd] <= result_i;
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_rd_val[p] = ({1'b0, w_adr[p]} < NWORDS) ? r_mem[w_adr[p]] : '0;
`ifdef MOR1KX_RF_BYPASS_EN
            if (w_wren && r_rfd == w_adr[p])
                w_rd_val[p] = result_i;
`endif
            if (ZR0 && w_adr[p] == '0)
                w_rd_val[p] = '0;
        end
    end

`ifdef MOR1KX_RF_BYPASS_EN
    // A held operand tracks later writes to the register it was read from.
    always_comb begin
        for (int p = 0; p < P; p++)
            w_hold_byp[p] = w_wren && (r_rfd == r_rd[p]) && !(ZR0 && r_rd[p] == '0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rfd <= '0;
            r_rd  <= '0;
            r_out <= '0;
        end else if (w_cap) begin
            r_rfd <= rfd_adr_i;
            r_rd  <= w_adr;
            r_out <= w_rd_val;
        end
`ifdef MOR1KX_RF_BYPASS_EN
        else begin
            for (int p = 0; p < P; p++)
                if (w_hold_byp[p])
                    r_out[p] <= result_i;
        end
`endif
    end

endmodule
